// File: rtl/score_pkg.sv
// Shared types and constants for the score manager.
//   score_state_t : top-level game/display sequencing states
//   SCORE_MAX     : saturation ceiling of the 4-digit score
//   REQ_HIT/BONUS : bit index of each requester in add_req/add_ack
//   sat_add       : 17-bit add of score and points, clamped to SCORE_MAX
package score_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    FINAL_SCORE,
    FINAL_HIGH
  } score_state_t;

  localparam logic [15:0] SCORE_MAX = 16'd9999;

  localparam int unsigned REQ_HIT   = 0;
  localparam int unsigned REQ_BONUS = 1;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [7:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {9'd0, b};
    return (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[15:0];
  endfunction

endpackage

// File: rtl/score_manager_if.sv
// Game-side bundle of the score manager.
//   master : game FSM / requesters (drive start/over pulses and point requests)
//   slave  : score_manager (returns acks and the display-facing outputs)
interface score_manager_if;
  import score_pkg::*;

  logic        game_start;
  logic        game_over;
  logic [1:0]  add_req;
  logic [7:0]  add_val0;
  logic [7:0]  add_val1;
  logic [1:0]  add_ack;
  logic [15:0] score;
  logic [15:0] high_score;
  logic        show_high;
  logic        blank;
  logic        new_high;

  modport master (
    output game_start, game_over, add_req, add_val0, add_val1,
    input  add_ack, score, high_score, show_high, blank, new_high
  );

  modport slave (
    input  game_start, game_over, add_req, add_val0, add_val1,
    output add_ack, score, high_score, show_high, blank, new_high
  );

endinterface

// File: rtl/score_arbiter.sv
// Two-way round-robin arbiter (purely combinational; pointer register lives in the parent).
//   req_i   : eligible requests, bit REQ_HIT / REQ_BONUS
//   en_i    : when low, no grant is issued and the pointer holds
//   ptr_i   : requester favoured when both request
//   gnt_o   : one-hot grant
//   ptr_d_o : next pointer value, always the requester not just granted
module score_arbiter
  import score_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       en_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o,
  output logic       ptr_d_o
);

  always_comb begin
    gnt_o   = 2'b00;
    ptr_d_o = ptr_i;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o[REQ_HIT]   = 1'b1;
        2'b10:   gnt_o[REQ_BONUS] = 1'b1;
        2'b11: begin
          if (ptr_i) gnt_o[REQ_BONUS] = 1'b1;
          else       gnt_o[REQ_HIT]   = 1'b1;
        end
        default: gnt_o = 2'b00;
      endcase
      if (gnt_o != 2'b00) ptr_d_o = gnt_o[REQ_HIT];
    end
  end

endmodule

// File: rtl/score_manager.sv
// Owns the game score and sequences the score display.
//   clk, reset   : system clock, asynchronous active-high reset
//   bus (slave)  : start/over pulses and point requests in; acks, score, high score
//                  and display controls (show_high, blank, new_high) out
// Points are accumulated with saturation at SCORE_MAX during play. After game over the
// display alternates final/high score every HOLD_CYCLES and blinks every BLINK_CYCLES
// when the game set a new record.
module score_manager
  import score_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES  = 50_000_000,
  parameter int unsigned BLINK_CYCLES = 12_500_000
) (
  input logic            clk,
  input logic            reset,
  score_manager_if.slave bus
);

  localparam int unsigned HoldW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned BlinkW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [HoldW-1:0]  HoldLast  = HoldW'(HOLD_CYCLES - 1);
  localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_CYCLES - 1);

  score_state_t      state_q, state_d;
  logic [15:0]       score_q, score_d;
  logic [15:0]       high_q, high_d;
  logic              new_high_q, new_high_d;
  logic              blank_q, blank_d;
  logic [1:0]        ack_q;
  logic              ptr_q, ptr_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic [BlinkW-1:0] blink_q, blink_d;

  logic [1:0]  req_elig;
  logic [1:0]  gnt;
  logic [7:0]  gnt_val;
  logic [15:0] next_score;

  // A request still high during its own ack cycle is the tail of the one just served.
  assign req_elig = bus.add_req & ~ack_q;

  // Acks are issued in every state so requesters never stall.
  score_arbiter u_arb (
    .req_i   (req_elig),
    .en_i    (1'b1),
    .ptr_i   (ptr_q),
    .gnt_o   (gnt),
    .ptr_d_o (ptr_d)
  );

  assign gnt_val    = gnt[REQ_BONUS] ? bus.add_val1 : bus.add_val0;
  assign next_score = ((state_q == PLAY) && (gnt != 2'b00)) ? sat_add(score_q, gnt_val)
                                                             : score_q;

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    new_high_d = new_high_q;
    blank_d    = blank_q;
    hold_d     = hold_q;
    blink_d    = blink_q;
    if (bus.game_start) begin
      state_d    = PLAY;
      score_d    = 16'd0;
      new_high_d = 1'b0;
      blank_d    = 1'b0;
      hold_d     = '0;
      blink_d    = '0;
    end else begin
      case (state_q)
        PLAY: begin
          score_d = next_score;
          if (bus.game_over) begin
            state_d = FINAL_SCORE;
            hold_d  = '0;
            blink_d = '0;
            blank_d = 1'b0;
            if (next_score > high_q) begin
              high_d     = next_score;
              new_high_d = 1'b1;
            end
          end
        end
        FINAL_SCORE, FINAL_HIGH: begin
          if (hold_q == HoldLast) begin
            hold_d  = '0;
            state_d = (state_q == FINAL_SCORE) ? FINAL_HIGH : FINAL_SCORE;
          end else begin
            hold_d = hold_q + 1'b1;
          end
          // Free-running blink; blank only ever leaves 0 after a record.
          if (blink_q == BlinkLast) begin
            blink_d = '0;
            blank_d = new_high_q & ~blank_q;
          end else begin
            blink_d = blink_q + 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      score_q    <= 16'd0;
      high_q     <= 16'd0;
      new_high_q <= 1'b0;
      blank_q    <= 1'b0;
      ack_q      <= 2'b00;
      ptr_q      <= 1'b0;
      hold_q     <= '0;
      blink_q    <= '0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      high_q     <= high_d;
      new_high_q <= new_high_d;
      blank_q    <= blank_d;
      ack_q      <= gnt;
      ptr_q      <= ptr_d;
      hold_q     <= hold_d;
      blink_q    <= blink_d;
    end
  end

  assign bus.add_ack    = ack_q;
  assign bus.score      = score_q;
  assign bus.high_score = high_q;
  assign bus.new_high   = new_high_q;
  assign bus.blank      = blank_q;
  assign bus.show_high  = (state_q == FINAL_HIGH);

endmodule

// File: doc/score_manager.md
# score_manager

Sequential controller that owns the game score and sequences what the 4-digit score display shows. It arbitrates point-add requests from two requesters (hit logic and bonus logic), accumulates with saturation at 9999, and tracks the session high score. After game over it alternates the display between final score and high score, blinking on a new record. It sits between the game FSM and `score_display`; its `score` output drives that block through an external mux selected by `show_high`.

## Interface
- `HOLD_CYCLES`, default 50_000_000: cycles each view is held in the final sequence (1 s at 50 MHz).
- `BLINK_CYCLES`, default 12_500_000: cycles per blink half-period on a new high score.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `game_start`  in  1  one-cycle pulse; clears the score and enters play.
- `game_over`  in  1  one-cycle pulse; ends play.
- `add_req`  in  2  per-requester level request, held high until acked; bit 0 is hit, bit 1 is bonus.
- `add_val0`  in  8  points for requester 0, stable while `add_req[0]` is high.
- `add_val1`  in  8  points for requester 1, stable while `add_req[1]` is high.
- `add_ack`  out  2  one-hot, one-cycle acknowledge.
- `score`  out  16  current score, 0..9999.
- `high_score`  out  16  session high score, 0..9999.
- `show_high`  out  1  display select: 0 shows `score`, 1 shows `high_score`.
- `blank`  out  1  when 1, the display is forced blank.
- `new_high`  out  1  the last game set a new high score.

## Operation
- States: IDLE, PLAY, FINAL_SCORE, FINAL_HIGH.
- Reset value of every output is 0. Reset state is IDLE.
- IDLE:
  - `game_start` → PLAY; `score`←0, `new_high`←0.
  - `game_over` is ignored.
- PLAY:
  - At most one grant per cycle, round-robin between the two requesters.
  - The priority pointer starts at 0 after reset. After each grant it points at the other requester.
  - On grant: `score` ← min(`score` + val, 9999). The sum is computed at 17 bits; there is no wrap.
  - `game_over` → FINAL_SCORE. In the same cycle, if next_score > `high_score`: `high_score`←next_score and `new_high`←1.
  - next_score is the post-add value, so a grant coincident with `game_over` is counted.
- FINAL_SCORE / FINAL_HIGH:
  - `show_high` = 0 / 1 respectively.
  - A hold counter toggles between the two states every HOLD_CYCLES, indefinitely.
  - If `new_high` is set, `blank` toggles every BLINK_CYCLES; otherwise `blank` = 0.
- Requests outside PLAY are acked and discarded, so requesters never stall. Round-robin still applies to these acks.
- `game_start` in any state → PLAY, score cleared. It clears the hold counter, the blink counter, `blank`, `show_high` and `new_high`. `high_score` is retained.
- `game_start` and `game_over` in the same cycle: `game_start` wins.

## Timing
- `add_ack[i]` is registered and asserted in the cycle after the grant decision. The updated `score` is visible in that same cycle.
- A requester drops `add_req` in the cycle it sees `add_ack`.
- A request still high in the cycle after its ack is treated as a new request. It is re-granted only when the other requester is idle or after the other requester is served.
- With both requesters continuously requesting, acks alternate 0, 1, 0, 1… at one ack per cycle.
- FINAL_SCORE is entered on the cycle after `game_over`. The first toggle to FINAL_HIGH occurs exactly HOLD_CYCLES cycles later.
- `blank` first rises BLINK_CYCLES cycles after entering FINAL_SCORE.
- Reset asserted mid-operation clears everything immediately, including `high_score`. Any pending request is not acked.

## Structure
- Package `score_pkg` holds:
  - the state enum `score_state_t` (IDLE, PLAY, FINAL_SCORE, FINAL_HIGH);
  - `SCORE_MAX` = 16'd9999;
  - the requester-index constants `REQ_HIT` = 0 and `REQ_BONUS` = 1.
- One sub-module, `score_arbiter`: a 2-way round-robin arbiter. Inputs are `add_req` and an enable; outputs are a one-hot grant and the pointer update.
- Saturating add, high-score compare and the hold/blink counters live in `score_manager`.

## Test plan
- **Reset, then start and single add.** Apply reset, pulse `game_start`, hold `add_req`=01 with `add_val0`=25.
  - Required: `add_ack`=01 for exactly one cycle; `score`=25 in that cycle.
- **Contention.** `add_req`=11 held for 4 cycles, `add_val0`=1, `add_val1`=10.
  - Required: acks alternate 01, 10, 01, 10; `score` ends at 22.
- **Saturation.** Start from `score`=9990 and grant `add_val1`=200.
  - Required: `score`=9999; a further grant leaves 9999.
- **Game over with a new high.** `high_score`=0, `score`=120, `game_over` pulsed coincident with a grant of 5. Run with `HOLD_CYCLES`=8 and `BLINK_CYCLES`=2.
  - Required: `high_score`=125 and `new_high`=1.
  - `show_high` toggles every 8 cycles; `blank` toggles every 2 cycles.
- **Game over without a new high.** Next game scores 50, then `game_over`.
  - Required: `high_score` stays 125; `new_high`=0; `blank` stays 0.
- **Simultaneous events and reset mid-operation.**
  - `game_start` and `game_over` in the same cycle → PLAY with `score`=0.
  - Reset asserted in FINAL_HIGH → every output is 0 within the same cycle.
